// File: rtl/mux_2to1_arbiter.sv
// Two-requester arbiter with a registered 2:1 output mux.
// A requester may keep the grant for at most MAX_HOLD beats while the other one waits.
module mux_2to1_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    localparam logic [2:0] HOLD_LAST = 3'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_hold_cnt;
    logic             r_last_sel;
    logic             r_sel;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             w_xfer_a;
    logic             w_xfer_b;
    logic             w_hold_done;

    assign w_xfer_a    = (r_state == GRANT_A) && req_a;
    assign w_xfer_b    = (r_state == GRANT_B) && req_b;
    assign w_hold_done = (r_hold_cnt == HOLD_LAST);

    assign gnt_a     = (r_state == GRANT_A);
    assign gnt_b     = (r_state == GRANT_B);
    assign sel       = r_sel;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

    // On a tie in IDLE the requester that was not served last wins.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_a && req_b)
                    w_state_next = r_last_sel ? GRANT_A : GRANT_B;
                else if (req_a)
                    w_state_next = GRANT_A;
                else if (req_b)
                    w_state_next = GRANT_B;
            end
            GRANT_A: begin
                if (!req_a)
                    w_state_next = req_b ? GRANT_B : IDLE;
                else if (w_hold_done && req_b)
                    w_state_next = GRANT_B;
            end
            GRANT_B: begin
                if (!req_b)
                    w_state_next = req_a ? GRANT_A : IDLE;
                else if (w_hold_done && req_a)
                    w_state_next = GRANT_A;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold_cnt <= 3'd0;
            r_last_sel <= 1'b1;
        end else begin
            r_state <= w_state_next;
            // Counter saturates so a lone requester keeps streaming.
            if (w_state_next != r_state)
                r_hold_cnt <= 3'd0;
            else if ((w_xfer_a || w_xfer_b) && !w_hold_done)
                r_hold_cnt <= r_hold_cnt + 3'd1;
            if (w_state_next == GRANT_A && r_state != GRANT_A)
                r_last_sel <= 1'b0;
            else if (w_state_next == GRANT_B && r_state != GRANT_B)
                r_last_sel <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_sel       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_xfer_a) begin
            r_out_data  <= data_a;
            r_sel       <= 1'b0;
            r_out_valid <= 1'b1;
        end else if (w_xfer_b) begin
            r_out_data  <= data_b;
            r_sel       <= 1'b1;
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_2to1_arbiter.sv
// Directed bench for mux_2to1_arbiter: expected beats are queued per test and
// a forked monitor compares every presented output beat against that queue.
module tb_mux_2to1_arbiter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;

    mux_2to1_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH:0]   exp_q[$];
    logic [WIDTH-1:0] a_q[$];
    logic [WIDTH-1:0] b_q[$];
    logic [WIDTH:0]   mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_beat(input logic s, input logic [WIDTH-1:0] d);
        exp_q.push_back({s, d});
    endtask

    // One clock cycle of requester behaviour: request while beats remain, advance on transfer.
    task automatic step();
        logic ta;
        logic tb;
        req_a  = (a_q.size() != 0);
        data_a = req_a ? a_q[0] : '0;
        req_b  = (b_q.size() != 0);
        data_b = req_b ? b_q[0] : '0;
        ta = gnt_a && req_a;
        tb = gnt_b && req_b;
        @(posedge clk);
        if (ta) void'(a_q.pop_front());
        if (tb) void'(b_q.pop_front());
        #1;
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || a_q.size() != 0 || b_q.size() != 0) && n < max_cycles) begin
            step();
            n++;
        end
        step();
        step();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_q.delete();
        b_q.delete();
        req_a = 1'b0;
        req_b = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = '0;
        data_b = '0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got sel=%0d data=0x%0h, none expected at %0t",
                                 sel, out_data, $time);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("beat", 32'({sel, out_data}), 32'(mon_exp));
                    end
                end
            end
            begin
                #100000;
                $display("FAIL watchdog: simulation did not complete in time");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("rst_gnt_b", 32'(gnt_b), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        step();

        // Single requester: three beats then back to IDLE.
        a_q = '{8'h11, 8'h22, 8'h33};
        expect_beat(1'b0, 8'h11);
        expect_beat(1'b0, 8'h22);
        expect_beat(1'b0, 8'h33);
        step();
        chk("single_gnt_latency", 32'(gnt_a), 32'd1);
        step();
        chk("single_valid_latency", 32'(out_valid), 32'd1);
        drain("single_drain", 20);
        chk("single_idle", 32'({gnt_a, gnt_b}), 32'd0);

        // Tie from reset, both held: 4 A, 4 B, 4 A, 4 B without gaps.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a_q.push_back(8'(8'hA0 + i));
            b_q.push_back(8'(8'hB0 + i));
        end
        for (int i = 0; i < 4; i++) expect_beat(1'b0, 8'(8'hA0 + i));
        for (int i = 0; i < 4; i++) expect_beat(1'b1, 8'(8'hB0 + i));
        for (int i = 4; i < 8; i++) expect_beat(1'b0, 8'(8'hA0 + i));
        for (int i = 4; i < 8; i++) expect_beat(1'b1, 8'(8'hB0 + i));
        step();
        chk("tie_gnt", 32'({gnt_a, gnt_b}), 32'b10);
        step();
        for (int i = 0; i < 16; i++) begin
            chk("hold_no_gap_valid", 32'(out_valid), 32'd1);
            chk("hold_grant_held", 32'(gnt_a | gnt_b), 32'd1);
            step();
        end
        drain("hold_drain", 20);

        // Saturation: lone requester streams 10 beats without losing the grant.
        for (int i = 0; i < 10; i++) begin
            a_q.push_back(8'(8'h40 + i));
            expect_beat(1'b0, 8'(8'h40 + i));
        end
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            chk("sat_gnt_a", 32'(gnt_a), 32'd1);
            chk("sat_valid", 32'(out_valid), 32'd1);
            step();
        end
        drain("sat_drain", 20);

        // Asynchronous reset between edges in the middle of an A burst.
        a_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        expect_beat(1'b0, 8'h61);
        step();
        step();
        step();
        #1;
        rst = 1'b1;
        #1;
        chk("async_gnt_a", 32'(gnt_a), 32'd0);
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_data", 32'(out_data), 32'd0);
        a_q.delete();
        req_a = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_q = '{8'h71};
        b_q = '{8'h81};
        expect_beat(1'b0, 8'h71);
        expect_beat(1'b1, 8'h81);
        step();
        chk("post_rst_tie_gnt", 32'({gnt_a, gnt_b}), 32'b10);
        drain("post_rst_drain", 20);

        // Handoff: A drops while B is pending, grant moves without a gap.
        a_q = '{8'h91, 8'h92};
        expect_beat(1'b0, 8'h91);
        expect_beat(1'b0, 8'h92);
        expect_beat(1'b1, 8'hAB);
        step();
        b_q.push_back(8'hAB);
        step();
        step();
        step();
        chk("handoff_gnt", 32'({gnt_a, gnt_b}), 32'b01);
        step();
        chk("handoff_beat", 32'({out_valid, sel, out_data}), 32'h3AB);
        drain("handoff_drain", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
